// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, TX state encoding and the baud divider helper.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // A zero baud rate is rejected at elaboration; guard the divide so the check can report it.
  function automatic int clkdiv(int clkf, int br);
    return (br > 0) ? clkf / br : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the shared UART TX: byte requests in, ack/grant/busy and serial line out.
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              tx;

  modport master (output req, data, input ack, grant_id, busy, tx);
  modport slave  (input req, data, output ack, grant_id, busy, tx);
endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit tick counter: free-runs 0..CLKS_PER_BIT-1, restart forces 0, bit_done on the last tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  assign bit_done = (cnt == LAST);
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NREQ byte requesters, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int BR   = 115200,
  parameter int CLKF = 50000000,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int CPB = clkdiv(CLKF, BR);
  localparam int IDW = $clog2(NREQ);

  if (BR <= 0) begin : g_bad_br
    $fatal(1, "uart_tx_arbiter: BR must be nonzero");
  end else if ((CLKF % BR) != 0 || CLKF < 2 * BR) begin : g_bad_clkf
    $fatal(1, "uart_tx_arbiter: CLKF must be a multiple of BR and at least 2*BR");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $fatal(1, "uart_tx_arbiter: NREQ must be in 2..16");
  end

  tx_state_e      state, state_nx;
  logic [7:0]     shreg;
  logic [2:0]     bit_idx;
  logic [IDW-1:0] rr_ptr, grant_id_q, winner, scan_idx;
  logic [IDW+2:0] sel;
  logic           found, grant, bit_done, last_bit;
`ifdef UART_TX_PARITY_EN
  logic           par_q;
`endif

  uart_bit_timer #(.CLKS_PER_BIT(CPB)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (grant),
    .bit_done (bit_done)
  );

  // First pending request at or after rr_ptr, wrapping.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Gating with reset keeps ack low while held in reset even if requests are pending.
  assign grant    = reset && found && (state == IDLE || (state == STOP && bit_done));
  assign sel      = {winner, 3'b000};
  assign last_bit = (bit_idx == 3'(UART_DATA_BITS - 1));

  always_comb begin
    bus.ack = '0;
    if (grant) bus.ack[winner] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (grant) state_nx = START;
      START:  if (bit_done) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_done && last_bit) state_nx = PARITY;
      PARITY: if (bit_done) state_nx = STOP;
`else
      DATA:   if (bit_done && last_bit) state_nx = STOP;
`endif
      STOP:   if (bit_done) state_nx = grant ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      grant_id_q <= '0;
      rr_ptr     <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (grant) begin
        shreg      <= bus.data[sel +: 8];
        bit_idx    <= '0;
        grant_id_q <= winner;
        rr_ptr     <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
`ifdef UART_TX_PARITY_EN
        par_q      <= ^bus.data[sel +: 8];
`endif
      end else if (state == DATA && bit_done) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // tx decodes straight from state so an async reset returns the line high immediately.
  always_comb begin
    bus.tx = 1'b1;
    case (state)
      START:  bus.tx = 1'b0;
      DATA:   bus.tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: bus.tx = par_q;
`endif
      default: bus.tx = 1'b1;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: CLKF=16, BR=2 (8 clocks per bit), NREQ=4.
module tb_uart_tx_arbiter;
  localparam int CPB  = 8;
  localparam int NREQ = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.BR(2), .CLKF(16), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int mptr = 0;
  logic [7:0] dbyte [NREQ];

  // Reference arbiter: first pending index at/after the pointer, wrapping.
  function automatic int model_pick(int ptr, logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Expected tx value for every clock of one frame, start bit first.
  function automatic logic [FL-1:0] model_wave(logic [7:0] b);
    logic [NB-1:0] bits;
    logic [FL-1:0] w;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    for (int i = 0; i < FL; i++) w[i] = bits[i / CPB];
    return w;
  endfunction

  task automatic set_data(input int i, input logic [7:0] v);
    dbyte[i] = v;
    bus.data[i*8 +: 8] = v;
  endtask

  // Samples FL consecutive cycles; the last sample is the stop-bit end cycle.
  task automatic capture(output logic [FL-1:0] txw, output logic [FL-1:0] bw,
                         output logic am, output logic [NREQ-1:0] al);
    txw = '0; bw = '0; am = 1'b0; al = '0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      txw[c] = bus.tx;
      bw[c]  = bus.busy;
      if (c < FL - 1 && bus.ack != '0) am = 1'b1;
      if (c == FL - 1) al = bus.ack;
    end
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.data = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
    checks++; if (bus.grant_id !== '0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", bus.grant_id); end
    reset = 1'b1;
    mptr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== '0) begin
        failures++; $display("FAIL idle_after_reset tx=%b busy=%b ack=%b exp tx=1 busy=0 ack=0", bus.tx, bus.busy, bus.ack);
      end
    end
  endtask

  task automatic test_single();
    logic [FL-1:0] txw, bw;
    logic am;
    logic [NREQ-1:0] al;
    int w;
    @(negedge clk);
    set_data(2, 8'hA5);
    bus.req = 4'b0100;
    #1;
    w = model_pick(mptr, bus.req);
    mptr = (w + 1) % NREQ;
    checks++; if (bus.ack !== NREQ'(1) << w) begin failures++; $display("FAIL single_ack got=%b exp=%b", bus.ack, NREQ'(1) << w); end
    @(posedge clk); #1;
    bus.req = '0;
    checks++; if (bus.grant_id !== 2'(w)) begin failures++; $display("FAIL single_gid got=%0d exp=%0d", bus.grant_id, w); end
    capture(txw, bw, am, al);
    checks++; if (txw !== model_wave(8'hA5)) begin failures++; $display("FAIL single_wave got=%h exp=%h", txw, model_wave(8'hA5)); end
    checks++; if (bw !== '1) begin failures++; $display("FAIL single_busy got=%h exp=all ones", bw); end
    checks++; if (am !== 1'b0 || al !== '0) begin failures++; $display("FAIL single_extra_ack mid=%b last=%b exp 0", am, al); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL single_tx_idle got=%b exp=1", bus.tx); end
  endtask

  task automatic test_round_robin();
    logic [FL-1:0] txw, bw;
    logic am;
    logic [NREQ-1:0] al, cur_ack;
    logic [7:0] b;
    int w;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    mptr = 0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'($urandom));
    bus.req = 4'b1111;
    #1;
    cur_ack = bus.ack;
    for (int f = 0; f < 5; f++) begin
      w = model_pick(mptr, bus.req);
      mptr = (w + 1) % NREQ;
      b = dbyte[w];
      checks++; if (cur_ack !== NREQ'(1) << w) begin failures++; $display("FAIL rr_ack frame=%0d got=%b exp=%b", f, cur_ack, NREQ'(1) << w); end
      @(posedge clk); #1;
      checks++; if (bus.grant_id !== 2'(w)) begin failures++; $display("FAIL rr_gid frame=%0d got=%0d exp=%0d", f, bus.grant_id, w); end
      set_data(w, 8'($urandom));
      if (f == 4) bus.req = '0;
      capture(txw, bw, am, al);
      cur_ack = al;
      checks++; if (txw !== model_wave(b)) begin failures++; $display("FAIL rr_wave frame=%0d got=%h exp=%h", f, txw, model_wave(b)); end
      checks++; if (bw !== '1) begin failures++; $display("FAIL rr_busy frame=%0d got=%h exp=all ones", f, bw); end
      checks++; if (am !== 1'b0) begin failures++; $display("FAIL rr_mid_ack frame=%0d got=%b exp=0", f, am); end
    end
    checks++; if (cur_ack !== '0) begin failures++; $display("FAIL rr_final_ack got=%b exp=0", cur_ack); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_busy_end got=%b exp=0", bus.busy); end
  endtask

  // Directed wrap/skip patterns first, then random request sets.
  task automatic test_arbitration();
    logic [NREQ-1:0] pats [3];
    logic [FL-1:0] txw, bw;
    logic am;
    logic [NREQ-1:0] al, r;
    logic [7:0] b;
    int w;
    pats[0] = 4'b0100; pats[1] = 4'b0010; pats[2] = 4'b1001;
    for (int it = 0; it < 9; it++) begin
      r = (it < 3) ? pats[it] : NREQ'($urandom_range(1, 15));
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) set_data(i, 8'($urandom));
      bus.req = r;
      #1;
      w = model_pick(mptr, r);
      mptr = (w + 1) % NREQ;
      b = dbyte[w];
      checks++; if (bus.ack !== NREQ'(1) << w) begin failures++; $display("FAIL arb_ack it=%0d req=%b got=%b exp=%b", it, r, bus.ack, NREQ'(1) << w); end
      @(posedge clk); #1;
      bus.req = '0;
      checks++; if (bus.grant_id !== 2'(w)) begin failures++; $display("FAIL arb_gid it=%0d got=%0d exp=%0d", it, bus.grant_id, w); end
      capture(txw, bw, am, al);
      checks++; if (txw !== model_wave(b)) begin failures++; $display("FAIL arb_wave it=%0d got=%h exp=%h", it, txw, model_wave(b)); end
      checks++; if (bw !== '1) begin failures++; $display("FAIL arb_busy it=%0d got=%h exp=all ones", it, bw); end
      checks++; if (am !== 1'b0 || al !== '0) begin failures++; $display("FAIL arb_extra_ack it=%0d mid=%b last=%b exp 0", it, am, al); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arb_busy_end it=%0d got=%b exp=0", it, bus.busy); end
    end
  endtask

  task automatic test_reset_mid();
    logic [FL-1:0] txw, bw;
    logic am;
    logic [NREQ-1:0] al;
    logic [7:0] b;
    int w;
    b = 8'($urandom) & 8'hEF;
    @(negedge clk);
    set_data(0, b);
    bus.req = 4'b0001;
    #1;
    w = model_pick(mptr, bus.req);
    checks++; if (bus.ack !== NREQ'(1) << w) begin failures++; $display("FAIL rmid_ack got=%b exp=%b", bus.ack, NREQ'(1) << w); end
    @(posedge clk);
    // Data bit 4 occupies frame cycles 41..48 after the ack cycle.
    repeat (44) @(negedge clk);
    checks++; if (bus.tx !== b[4]) begin failures++; $display("FAIL rmid_bit4 got=%b exp=%b", bus.tx, b[4]); end
    reset = 1'b0;
    #1;
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL rmid_tx got=%b exp=1", bus.tx); end
    checks++; if (bus.busy !== 1'b0 || bus.ack !== '0) begin failures++; $display("FAIL rmid_busy_ack busy=%b ack=%b exp 0", bus.busy, bus.ack); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mptr = 0;
    #1;
    w = model_pick(mptr, bus.req);
    mptr = (w + 1) % NREQ;
    checks++; if (bus.ack !== NREQ'(1) << w) begin failures++; $display("FAIL rmid_reack got=%b exp=%b", bus.ack, NREQ'(1) << w); end
    @(posedge clk); #1;
    bus.req = '0;
    capture(txw, bw, am, al);
    checks++; if (txw !== model_wave(b)) begin failures++; $display("FAIL rmid_wave got=%h exp=%h", txw, model_wave(b)); end
    checks++; if (am !== 1'b0 || al !== '0) begin failures++; $display("FAIL rmid_extra_ack mid=%b last=%b exp 0", am, al); end
    @(negedge clk);
  endtask

  task automatic test_withdrawn();
    logic [FL-1:0] txw;
    logic am;
    logic [7:0] b;
    int w;
    b = 8'($urandom);
    @(negedge clk);
    set_data(3, b);
    set_data(1, 8'($urandom));
    bus.req = 4'b1000;
    #1;
    w = model_pick(mptr, bus.req);
    mptr = (w + 1) % NREQ;
    checks++; if (bus.ack !== NREQ'(1) << w) begin failures++; $display("FAIL wd_ack got=%b exp=%b", bus.ack, NREQ'(1) << w); end
    @(posedge clk); #1;
    bus.req = '0;
    am = 1'b0; txw = '0;
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      txw[c] = bus.tx;
      if (bus.ack != '0) am = 1'b1;
      if (c == 20) bus.req = 4'b0010;
      if (c == 40) bus.req = '0;
    end
    checks++; if (txw !== model_wave(b)) begin failures++; $display("FAIL wd_wave got=%h exp=%h", txw, model_wave(b)); end
    checks++; if (am !== 1'b0) begin failures++; $display("FAIL wd_ack_during_frame got=%b exp=0", am); end
    for (int c = 0; c < 2 * CPB; c++) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.busy !== 1'b0) am = 1'b1;
    end
    checks++; if (am !== 1'b0) begin failures++; $display("FAIL wd_no_frame got=%b exp=0", am); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_arbitration();
    test_reset_mid();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
